// File: rtl/mem_access_stage.sv
// RV32I memory stage: loads/stores over a req/ack data port, registered MEM/WB outputs.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] store_data,
  input  logic            load,
  input  logic            store,
  input  logic [2:0]      fun3,
  input  logic [4:0]      rd_in,
  input  logic            reg_wr_in,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_wr,
  output logic            bus_err,
  output logic            misaligned
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q;
  logic [2:0]      fun3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            reg_wr_q;
  logic            is_load_q;

  logic            is_mem, passthru, misal_hit;
  logic            accept, trap, done, tmo;
  logic [1:0]      off;
  logic [3:0]      st_mask;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign is_mem   = load | store;
  assign off      = alu_res[1:0];
  assign stall    = (state_q == ACCESS);
  assign passthru = (state_q == IDLE) && valid_in && !is_mem;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misal_hit = 1'b0;
    case (fun3)
      3'b001, 3'b101: misal_hit = off[0];
      3'b010:         misal_hit = (off != 2'b00);
      default:        misal_hit = 1'b0;
    endcase
  end
`else
  assign misal_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    trap    = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && is_mem) begin
          if (misal_hit) begin
            trap = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store lane steering: replicate the datum so any byte enable sees the right bits.
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = store_data;
    case (fun3)
      3'b000: begin
        st_mask  = 4'(4'b0001 << off);
        st_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        st_mask  = 4'(4'b0011 << off);
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (fun3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      fun3_q     <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      reg_wr_q   <= 1'b0;
      is_load_q  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_reg_wr  <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;

      if (passthru) begin
        wb_valid  <= 1'b1;
        wb_data   <= alu_res;
        wb_rd     <= rd_in;
        wb_reg_wr <= reg_wr_in;
      end

      if (trap) begin
        misaligned <= 1'b1;
        wb_valid   <= 1'b1;
        wb_rd      <= rd_in;
        wb_reg_wr  <= 1'b0;
      end

      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= store;
        mem_addr  <= {alu_res[XLEN-1:2], 2'b00};
        mem_wdata <= st_wdata;
        mem_wmask <= st_mask;
        fun3_q    <= fun3;
        off_q     <= off;
        rd_q      <= rd_in;
        reg_wr_q  <= reg_wr_in;
        is_load_q <= load;
        cnt_q     <= '0;
      end

      if (done) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        wb_valid  <= 1'b1;
        wb_rd     <= rd_q;
        wb_reg_wr <= is_load_q & reg_wr_q;
        if (is_load_q) wb_data <= ld_data;
      end else if (tmo) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        bus_err   <= 1'b1;
        wb_valid  <= 1'b1;
        wb_rd     <= rd_q;
        wb_reg_wr <= 1'b0;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads, stores, timeout, misalign, reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_res, store_data;
  logic        load, store;
  logic [2:0]  fun3;
  logic [4:0]  rd_in;
  logic        reg_wr_in;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_wr, bus_err, misaligned;

  int checks = 0;
  int errors = 0;
  logic        seen_we;
  logic [3:0]  seen_wmask;
  logic [31:0] seen_wdata;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_res(alu_res),
    .store_data(store_data), .load(load), .store(store), .fun3(fun3),
    .rd_in(rd_in), .reg_wr_in(reg_wr_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_wr(wb_reg_wr), .bus_err(bus_err), .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one memory op, ack on the delay-th ACCESS cycle, stop one cycle after completion.
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int delay, input logic [31:0] rdata,
                        input logic [31:0] exp_addr);
    int stall_cnt;
    stall_cnt  = 0;
    valid_in   = 1'b1;
    load       = ld;
    store      = st;
    fun3       = f3;
    alu_res    = addr;
    store_data = sd;
    rd_in      = 5'd7;
    reg_wr_in  = 1'b1;
    tick();
    valid_in = 1'b0;
    load     = 1'b0;
    store    = 1'b0;
    seen_we    = mem_we;
    seen_wmask = mem_wmask;
    seen_wdata = mem_wdata;
    for (int i = 1; i <= delay; i++) begin
      if (stall) stall_cnt++;
      chk("addr_hold", mem_addr, exp_addr);
      chk("req_held", {31'b0, mem_req}, 32'd1);
      if (i == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("stall_cycles", stall_cnt, delay);
    chk("wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("req_drop", {31'b0, mem_req}, 32'd0);
    chk("wb_rd", {27'b0, wb_rd}, 32'd7);
  endtask

  initial begin
    int req_cnt, be_cnt, wv_cnt;
    rst = 1'b1; valid_in = 1'b0; alu_res = '0; store_data = '0;
    load = 1'b0; store = 1'b0; fun3 = 3'b0; rd_in = '0; reg_wr_in = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_stall",   {31'b0, stall},    32'd0);
    chk("rst_req",     {31'b0, mem_req},  32'd0);
    chk("rst_addr",    mem_addr,          32'd0);
    chk("rst_wbvalid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wbdata",  wb_data,           32'd0);
    chk("rst_buserr",  {31'b0, bus_err},  32'd0);
    rst = 1'b0;
    tick();

    // ALU pass-through
    valid_in = 1'b1; alu_res = 32'h0000_1234; rd_in = 5'd5; reg_wr_in = 1'b1;
    chk("add_stall_pre", {31'b0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("add_wbvalid", {31'b0, wb_valid},  32'd1);
    chk("add_wbdata",  wb_data,            32'h0000_1234);
    chk("add_wbrd",    {27'b0, wb_rd},     32'd5);
    chk("add_wbwr",    {31'b0, wb_reg_wr}, 32'd1);
    chk("add_stall",   {31'b0, stall},     32'd0);
    tick();
    chk("idle_wbvalid", {31'b0, wb_valid}, 32'd0);
    chk("idle_hold",    wb_data,           32'h0000_1234);

    // Loads
    mem_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'h100);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_wr",   {31'b0, wb_reg_wr}, 32'd1);
    chk("lw_we",   {31'b0, seen_we},   32'd0);
    mem_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000, 32'h100);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    mem_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000, 32'h100);
    chk("lbu_data", wb_data, 32'h00000080);
    mem_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80FF_0000, 32'h100);
    chk("lhu_data", wb_data, 32'h000080FF);
    mem_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF_0000, 32'h100);
    chk("lh_data", wb_data, 32'hFFFF80FF);

    // Stores
    mem_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 2, 32'h0, 32'h200);
    chk("sb_we",    {31'b0, seen_we},    32'd1);
    chk("sb_mask",  {28'b0, seen_wmask}, 32'b0010);
    chk("sb_wdata", seen_wdata,          32'hABABABAB);
    chk("sb_wr",    {31'b0, wb_reg_wr},  32'd0);
    mem_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 1, 32'h0, 32'h200);
    chk("sh_mask",  {28'b0, seen_wmask}, 32'b1100);
    chk("sh_wdata", seen_wdata,          32'hABCDABCD);
    mem_op(1'b0, 1'b1, 3'b010, 32'h204, 32'h1122_3344, 1, 32'h0, 32'h204);
    chk("sw_mask",  {28'b0, seen_wmask}, 32'b1111);
    chk("sw_wdata", seen_wdata,          32'h11223344);

    // Timeout with a late ack
    valid_in = 1'b1; load = 1'b1; fun3 = 3'b010; alu_res = 32'h300; rd_in = 5'd9; reg_wr_in = 1'b1;
    tick();
    valid_in = 1'b0; load = 1'b0;
    req_cnt = 0; be_cnt = 0; wv_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) req_cnt++;
      if (bus_err) begin
        be_cnt++;
        chk("tmo_wbvalid", {31'b0, wb_valid},  32'd1);
        chk("tmo_wbwr",    {31'b0, wb_reg_wr}, 32'd0);
      end
      if (wb_valid) wv_cnt++;
      mem_ack = (i == 20);
      tick();
    end
    mem_ack = 1'b0;
    chk("tmo_req_cycles", req_cnt, 32'd16);
    chk("tmo_buserr_cnt", be_cnt,  32'd1);
    chk("tmo_wbvalid_cnt", wv_cnt, 32'd1);
    chk("tmo_idle", {31'b0, stall}, 32'd0);

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    valid_in = 1'b1; load = 1'b1; fun3 = 3'b010; alu_res = 32'h102; rd_in = 5'd3; reg_wr_in = 1'b1;
    tick();
    valid_in = 1'b0; load = 1'b0;
    chk("mis_flag",    {31'b0, misaligned}, 32'd1);
    chk("mis_req",     {31'b0, mem_req},    32'd0);
    chk("mis_wbvalid", {31'b0, wb_valid},   32'd1);
    chk("mis_wbwr",    {31'b0, wb_reg_wr},  32'd0);
    chk("mis_stall",   {31'b0, stall},      32'd0);
    tick();
    chk("mis_pulse", {31'b0, misaligned}, 32'd0);
`else
    mem_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'hCAFEF00D, 32'h100);
    chk("mis_data", wb_data, 32'hCAFEF00D);
    chk("mis_flag", {31'b0, misaligned}, 32'd0);
`endif

    // Reset in the middle of an access
    valid_in = 1'b1; load = 1'b1; fun3 = 3'b010; alu_res = 32'h400; rd_in = 5'd4; reg_wr_in = 1'b1;
    tick();
    valid_in = 1'b0; load = 1'b0;
    tick();
    chk("mid_in_access", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_req",     {31'b0, mem_req},  32'd0);
    chk("mid_stall",   {31'b0, stall},    32'd0);
    chk("mid_addr",    mem_addr,          32'd0);
    chk("mid_wbvalid", {31'b0, wb_valid}, 32'd0);
    chk("mid_wbdata",  wb_data,           32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    chk("mid_late_ack", {31'b0, wb_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the RV32I pipelined core. Sits directly downstream of the EX/MEM pipeline register and consumes its registered ALU result as the effective address.
- Performs loads and stores over a req/ack data-memory port:
  - byte-lane masking on stores
  - sign/zero extension on loads
- Raises a stall to the upstream pipeline while an access is outstanding.
- Registers the result into a MEM/WB output stage.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for mem_ack before abandoning the access (range 2..255).
- XLEN, 32: data/address width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  upstream instruction valid.
- alu_res  in  32  effective address, or the ALU result for non-memory ops.
- store_data  in  32  rs2 value for stores.
- load  in  1  instruction is a load.
- store  in  1  instruction is a store. load and store are never both 1.
- fun3  in  3  RV32I funct3 (size and sign).
- rd_in  in  5  destination register.
- reg_wr_in  in  1  instruction writes rd.
- stall  out  1  upstream must hold its inputs (combinational, = state==ACCESS).
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_wdata  out  32  store data replicated to the byte lanes.
- mem_wmask  out  4  byte-enable.
- mem_ack  in  1  memory completion. Read data is valid when this is 1.
- mem_rdata  in  32  read word.
- wb_valid  out  1  MEM/WB entry valid (1-cycle pulse per instruction).
- wb_data  out  32  load result or passed-through alu_res.
- wb_rd  out  5  destination register.
- wb_reg_wr  out  1  write-enable for writeback.
- bus_err  out  1  1-cycle pulse: access timed out.
- misaligned  out  1  1-cycle pulse: misaligned access (see Optional Feature).

Behaviour:
- Reset:
  - state=IDLE, counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, wb_valid, wb_data, wb_rd, wb_reg_wr, bus_err and misaligned are all 0.
- FSM states: IDLE, ACCESS.
- IDLE, valid_in=1, load=store=0:
  - Next edge: wb_valid=1, wb_data=alu_res, wb_rd=rd_in, wb_reg_wr=reg_wr_in.
  - Latency 1, no stall.
- IDLE, valid_in=1, load or store:
  - Next edge: latch rd/fun3/addr[1:0], go to ACCESS, mem_req=1, mem_we=store.
  - mem_addr, mem_wdata and mem_wmask are registered and held stable until completion.
- ACCESS:
  - stall=1.
  - counter increments each cycle mem_ack=0.
  - Edge with mem_ack=1:
    - mem_req=0, go to IDLE.
    - wb_valid=1.
    - Load: wb_data=formatted mem_rdata, wb_reg_wr=latched reg_wr_in.
    - Store: wb_reg_wr=0.
  - Minimum memory-op latency: 2 edges from acceptance to wb_valid.
- Timeout: when counter reaches TIMEOUT_CYCLES-1 with no ack:
  - mem_req=0, bus_err=1, wb_valid=1, wb_reg_wr=0, go to IDLE.
  - mem_ack arriving while in IDLE is ignored.
- In IDLE, valid_in=0: wb_valid=0, and the wb_* data fields hold their values.
- Store lanes (o = addr[1:0]):
  - SB (000): mask=4'b0001<<o, wdata={4{sd[7:0]}}.
  - SH (001): mask=4'b0011<<o, wdata={2{sd[15:0]}}.
  - SW and other fun3 values: mask=4'b1111, wdata=sd.
- Load formatting:
  - LB (000) / LBU (100): byte lane o, sign/zero extended.
  - LH (001) / LHU (101): halfword lane addr[1], sign/zero extended.
  - LW (010) and 011/110/111: full word.
- Reset mid-access: mem_req drops at the reset edge. Any later ack is ignored. No wb_valid is produced.
- mem_we is only meaningful while mem_req=1.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0:
  - No memory request is issued.
  - Next edge: misaligned=1, wb_valid=1, wb_reg_wr=0.
  - Latency 1, no stall.
- Undefined:
  - misaligned is tied to 0.
  - The access proceeds with lane selection as specified in Behaviour (halfword uses addr[1], word ignores addr[1:0]).

Test Plan:
- ADD pass-through: alu_res=0x0000_1234, rd_in=5, reg_wr_in=1 in IDLE -> next edge wb_valid=1, wb_data=0x1234, wb_rd=5; stall never high.
- LW from 0x100, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x100 held for all 3 cycles; stall high 3 cycles; wb_data=0xDEADBEEF, wb_reg_wr=1.
- LB from 0x103 with rdata=0x80FF_0000 -> wb_data=0xFFFFFF80. LBU from the same address -> 0x00000080. LHU from 0x102 -> 0x000080FF.
- SB to 0x201 with store_data=0x0000_00AB -> mem_we=1, mem_wmask=4'b0010, mem_wdata=0xABABABAB, mem_addr=0x200; wb_reg_wr=0.
- No ack for TIMEOUT_CYCLES=16 cycles -> mem_req drops, bus_err pulses once, wb_valid=1 with wb_reg_wr=0, FSM returns to IDLE. A late ack causes no further wb_valid.
- With MISALIGN_TRAP_EN: LW at 0x102 -> no mem_req, misaligned=1 for 1 cycle, wb_reg_wr=0. Without the macro: mem_addr=0x100, normal completion. Separately, rst asserted mid-ACCESS -> all outputs 0 at the next edge.
